sap_ram: RTL and testbench
==========================

# sap_ram

Program/data RAM for the SAP-1 FPGA build: 16 × 8 storage read at the address presented by the MAR and driven onto the W-bus when enabled. It also owns the front-panel programming path: a debounced write strobe loads switch data into memory. An active-high clear sweeps all 16 locations to zero.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive high samples of prog_write required before a write commits (legal range 2–15)

- CLK  in  1  system clock; all state updates on rising edge
- CLR  in  1  synchronous, active-high reset; starts the zeroing sweep
- ram_address  in  4  read address from MAR output
- CE_bar  in  1  active-low output enable (run mode)
- ram_output  out  8  registered read data; 0 when not enabled
- prog_mode  in  1  1 = programming mode, 0 = run mode
- prog_address  in  4  programming address switches
- prog_data  in  8  programming data switches
- prog_write  in  1  raw write pushbutton (level, may bounce)
- prog_readback  out  8  registered mem[prog_address], for panel LEDs
- busy  out  1  high during CLEAR, ARMED, WRITE
- write_done  out  1  one-cycle pulse when a programming write commits

## Operation
- Storage: 16 words × 8 bits; no tristates, bus isolation is ram_output = 0.
- FSM states: CLEAR, IDLE, ARMED, WRITE, WAIT_RELEASE.
- CLR high at an edge: state ← CLEAR, sweep counter ← 0, debounce counter ← 0, ram_output ← 0, prog_readback ← 0, write_done ← 0. Overrides every other condition.
- CLEAR (CLR low): each edge writes mem[sweep] ← 0, sweep++; on the edge writing address 15 → IDLE. No programming writes are accepted; the sweep ignores prog_mode.
- IDLE: prog_mode=1 and prog_write=1 sampled → ARMED, debounce counter ← 1.
- ARMED: prog_write=0 or prog_mode=0 → IDLE, no write; else if counter+1 = DEBOUNCE_CYCLES → WRITE; else counter++.
- WRITE: on the next edge, mem[prog_address] ← prog_data (sampled on that edge), write_done ← 1, → WAIT_RELEASE. A commit is not aborted by prog_mode falling; only CLR aborts it.
- WAIT_RELEASE: prog_write=0 sampled → IDLE. A held button gives exactly one write.
- write_done clears on the edge after it sets.
- Read path (every edge, outside CLEAR): prog_mode=0 and CE_bar=0 → ram_output ← mem[ram_address]; otherwise ram_output ← 0. In CLEAR, ram_output ← 0.
- prog_readback ← mem[prog_address] every edge outside CLEAR; 0 in CLEAR.
- Read/write same address on same edge: read-before-write. Outputs show the old word on that edge and the new word one edge later.

## Timing
- After reset: ram_output=0, prog_readback=0, busy=1, write_done=0.
- Clear sweep: busy stays high for 16 edges after the first edge with CLR low; IDLE from edge 16.
- Read latency: 1 cycle from ram_address/CE_bar to ram_output.
- Write latency with DEBOUNCE_CYCLES=D: prog_write first sampled high at edge 0, high at edges 0..D−1 → WRITE after edge D−1. Memory is written and write_done=1 after edge D, and write_done=0 after edge D+1.
- A low sample at any edge 1..D−1 restarts debounce; the next high sample counts as edge 0.
- CLR mid-ARMED/WRITE: no write commits, write_done stays 0, the full 16-cycle sweep restarts.

## Test plan
- Reset sweep: preload garbage via writes, pulse CLR one cycle → busy high exactly 16 cycles, then every address reads 0x00 with CE_bar=0.
- Debounced write (D=4): prog_mode=1, addr=0x3, data=0xA5, prog_write high 6 cycles → write_done pulses once after edge 4, prog_readback=0xA5; run mode read of addr 3 gives 0xA5 one cycle after address.
- Bounce rejection: prog_write pattern 1,1,0,1,1,1,0 → no write_done, memory unchanged; then 4 highs → exactly one write.
- Held button: prog_write high 50 cycles → a single write_done pulse; data changed after commit is not written.
- Bus isolation: run mode with CE_bar=1 → ram_output=0; prog_mode=1 with CE_bar=0 → ram_output=0; sweep ram_address 0..15 with CE_bar=0 → each word after 1 cycle.
- Reset mid-write: CLR asserted on the edge the FSM is in WRITE → no write_done, memory all zero after 16 cycles, FSM back in IDLE.

Source files
------------

// File: rtl/sap_ram.sv
`default_nettype none
// ============================================================================
// Module      : sap_ram
// Description : SAP-1 16 x 8 program/data RAM. The run-mode read port feeds
//               the W-bus and is isolated by driving zero. A front-panel
//               programming path debounces the write pushbutton and commits
//               switch data to memory. CLR zeroes all 16 words with a
//               one-word-per-cycle sweep.
// Ports       : CLK, CLR           clock, synchronous active-high clear
//               ram_address, CE_bar  run-mode read address / output enable
//               ram_output         registered read data (0 when disabled)
//               prog_mode, prog_address, prog_data, prog_write  panel inputs
//               prog_readback      registered mem[prog_address]
//               busy, write_done   status outputs
// Revision    : 1.0  initial release
// ============================================================================
module sap_ram #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] ram_address,
    input  logic       CE_bar,
    output logic [7:0] ram_output,
    input  logic       prog_mode,
    input  logic [3:0] prog_address,
    input  logic [7:0] prog_data,
    input  logic       prog_write,
    output logic [7:0] prog_readback,
    output logic       busy,
    output logic       write_done
);

    typedef enum logic [2:0] {
        S_CLEAR        = 3'd0,
        S_IDLE         = 3'd1,
        S_ARMED        = 3'd2,
        S_WRITE        = 3'd3,
        S_WAIT_RELEASE = 3'd4
    } state_t;

    localparam logic [4:0] c_deb_target = 5'(DEBOUNCE_CYCLES);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_sweep;
    logic [3:0]  w_sweep_next;
    logic [3:0]  r_deb;
    logic [3:0]  w_deb_next;
    logic [4:0]  w_deb_inc;
    logic        w_mem_we;
    logic [3:0]  w_mem_waddr;
    logic [7:0]  w_mem_wdata;
    logic        w_commit;
    logic [7:0]  r_mem [16];

    // One extra bit so the compare against the target never wraps.
    assign w_deb_inc = {1'b0, r_deb} + 5'd1;

    assign busy = (r_state == S_CLEAR) || (r_state == S_ARMED) || (r_state == S_WRITE);

    always_comb begin
        w_state_next = r_state;
        w_sweep_next = r_sweep;
        w_deb_next   = r_deb;
        w_mem_we     = 1'b0;
        w_mem_waddr  = prog_address;
        w_mem_wdata  = prog_data;
        w_commit     = 1'b0;
        case (r_state)
            S_CLEAR: begin
                // Sweep ignores the panel entirely.
                w_mem_we     = 1'b1;
                w_mem_waddr  = r_sweep;
                w_mem_wdata  = 8'h00;
                w_sweep_next = r_sweep + 4'd1;
                if (r_sweep == 4'hF) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (prog_mode && prog_write) begin
                    w_state_next = S_ARMED;
                    w_deb_next   = 4'd1;
                end
            end
            S_ARMED: begin
                if (!prog_write || !prog_mode) begin
                    w_state_next = S_IDLE;
                end else if (w_deb_inc == c_deb_target) begin
                    w_state_next = S_WRITE;
                end else begin
                    w_deb_next = w_deb_inc[3:0];
                end
            end
            S_WRITE: begin
                // Committed regardless of prog_mode; only CLR can abort.
                w_mem_we     = 1'b1;
                w_commit     = 1'b1;
                w_state_next = S_WAIT_RELEASE;
            end
            S_WAIT_RELEASE: begin
                if (!prog_write) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state       <= S_CLEAR;
            r_sweep       <= 4'd0;
            r_deb         <= 4'd0;
            ram_output    <= 8'h00;
            prog_readback <= 8'h00;
            write_done    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sweep    <= w_sweep_next;
            r_deb      <= w_deb_next;
            write_done <= w_commit;
            if (r_state == S_CLEAR) begin
                ram_output    <= 8'h00;
                prog_readback <= 8'h00;
            end else begin
                // Nonblocking reads give read-before-write on a shared edge.
                ram_output    <= (!prog_mode && !CE_bar) ? r_mem[ram_address] : 8'h00;
                prog_readback <= r_mem[prog_address];
            end
        end
    end

    // Storage has no reset of its own; the CLEAR sweep zeroes it.
    always_ff @(posedge CLK) begin
        if (!CLR && w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sap_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap_ram
// Description : Self-checking bench for sap_ram. A behavioural model tracks
//               memory contents, the remaining clear sweep, the run of
//               consecutive button samples and the pending/held write, and
//               every cycle's outputs are compared against it. Directed
//               scenarios add literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sap_ram;

    localparam int D = 4;

    logic       CLK;
    logic       CLR;
    logic [3:0] ram_address;
    logic       CE_bar;
    logic [7:0] ram_output;
    logic       prog_mode;
    logic [3:0] prog_address;
    logic [7:0] prog_data;
    logic       prog_write;
    logic [7:0] prog_readback;
    logic       busy;
    logic       write_done;

    int errors = 0;
    int checks = 0;
    int wd_count = 0;

    sap_ram #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .ram_address  (ram_address),
        .CE_bar       (CE_bar),
        .ram_output   (ram_output),
        .prog_mode    (prog_mode),
        .prog_address (prog_address),
        .prog_data    (prog_data),
        .prog_write   (prog_write),
        .prog_readback(prog_readback),
        .busy         (busy),
        .write_done   (write_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [16];
    int         m_clear_left = 0;
    int         m_run = 0;
    bit         m_pending = 0;
    bit         m_held = 0;
    bit         m_valid = 0;
    logic [7:0] e_ram = 8'h00;
    logic [7:0] e_rb = 8'h00;
    logic       e_wd = 1'b0;
    logic       e_busy = 1'b1;

    always @(posedge CLK) begin
        if (CLR) begin
            m_valid      = 1;
            m_clear_left = 16;
            m_run        = 0;
            m_pending    = 0;
            m_held       = 0;
            e_ram        = 8'h00;
            e_rb         = 8'h00;
            e_wd         = 1'b0;
        end else if (m_clear_left > 0) begin
            m_mem[16 - m_clear_left] = 8'h00;
            m_clear_left--;
            e_ram = 8'h00;
            e_rb  = 8'h00;
            e_wd  = 1'b0;
        end else begin
            e_ram = (!prog_mode && !CE_bar) ? m_mem[ram_address] : 8'h00;
            e_rb  = m_mem[prog_address];
            e_wd  = 1'b0;
            if (m_pending) begin
                m_mem[prog_address] = prog_data;
                e_wd      = 1'b1;
                m_pending = 0;
                m_held    = 1;
            end else if (m_held) begin
                if (!prog_write) m_held = 0;
            end else if (prog_mode && prog_write) begin
                m_run++;
                if (m_run == D) begin
                    m_pending = 1;
                    m_run     = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        e_busy = (m_clear_left > 0) || (m_run > 0) || m_pending;
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("ram_output", ram_output, e_ram);
            chk("prog_readback", prog_readback, e_rb);
            chk("write_done", {7'd0, write_done}, {7'd0, e_wd});
            chk("busy", {7'd0, busy}, {7'd0, e_busy});
        end
        if (write_done === 1'b1) wd_count++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic hold_write(input logic [3:0] a, input logic [7:0] d, input int n);
        prog_mode    = 1'b1;
        prog_address = a;
        prog_data    = d;
        prog_write   = 1'b1;
        repeat (n) tick();
        prog_write = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wd0;
        int busy_cnt;
        logic pat [7];
        logic [7:0] exp_word [16];

        CLR = 1'b1; ram_address = 4'd0; CE_bar = 1'b1; prog_mode = 1'b0;
        prog_address = 4'd0; prog_data = 8'h00; prog_write = 1'b0;
        repeat (2) tick();
        chk("rst_ram_output", ram_output, 8'h00);
        chk("rst_readback", prog_readback, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h01);
        chk("rst_write_done", {7'd0, write_done}, 8'h00);

        CLR = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("sweep_busy", {7'd0, busy}, (i < 16) ? 8'h01 : 8'h00);
        end

        // Garbage preload, then clear again
        hold_write(4'd2, 8'hDE, 5);
        hold_write(4'd9, 8'hBE, 5);
        hold_write(4'd15, 8'hEF, 5);
        chk("preload_readback", prog_readback, 8'hEF);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        busy_cnt = busy ? 1 : 0;
        repeat (20) begin
            tick();
            if (busy) busy_cnt++;
        end
        chk("clr_busy_cycles", 8'(busy_cnt), 8'd16);
        prog_mode = 1'b0; CE_bar = 1'b0;
        for (int a = 0; a < 16; a++) begin
            ram_address = 4'(a);
            tick();
            chk("clr_read_zero", ram_output, 8'h00);
        end

        // Debounced write
        wd0 = wd_count;
        CE_bar = 1'b1; prog_mode = 1'b1; prog_address = 4'h3; prog_data = 8'hA5;
        prog_write = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("dbw_write_done", {7'd0, write_done}, (k == 5) ? 8'h01 : 8'h00);
        end
        chk("dbw_readback", prog_readback, 8'hA5);
        prog_write = 1'b0;
        repeat (2) tick();
        chk("dbw_pulse_count", 8'(wd_count - wd0), 8'd1);
        prog_mode = 1'b0; CE_bar = 1'b0; ram_address = 4'h3;
        tick();
        chk("run_read_3", ram_output, 8'hA5);
        ram_address = 4'h0;
        tick();
        chk("run_read_0", ram_output, 8'h00);

        // Bounce rejection
        wd0 = wd_count;
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        CE_bar = 1'b1; prog_mode = 1'b1; prog_address = 4'h5; prog_data = 8'h3C;
        for (int i = 0; i < 7; i++) begin
            prog_write = pat[i];
            tick();
        end
        tick();
        chk("bounce_no_write", 8'(wd_count - wd0), 8'd0);
        chk("bounce_mem_unchanged", prog_readback, 8'h00);
        prog_write = 1'b1;
        repeat (4) tick();
        prog_write = 1'b0;
        repeat (3) tick();
        chk("bounce_one_write", 8'(wd_count - wd0), 8'd1);
        chk("bounce_readback", prog_readback, 8'h3C);

        // Held button: one write, later data ignored
        wd0 = wd_count;
        prog_address = 4'h7; prog_data = 8'h11; prog_write = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) prog_data = 8'h22;
            tick();
        end
        prog_write = 1'b0;
        repeat (3) tick();
        chk("held_one_write", 8'(wd_count - wd0), 8'd1);
        chk("held_readback", prog_readback, 8'h11);

        // Bus isolation and full read sweep
        prog_mode = 1'b0; CE_bar = 1'b1; ram_address = 4'h3;
        tick();
        chk("iso_ce_high", ram_output, 8'h00);
        prog_mode = 1'b1; CE_bar = 1'b0;
        tick();
        chk("iso_prog_mode", ram_output, 8'h00);
        prog_mode = 1'b0;
        for (int a = 0; a < 16; a++) exp_word[a] = 8'h00;
        exp_word[3] = 8'hA5; exp_word[5] = 8'h3C; exp_word[7] = 8'h11;
        for (int a = 0; a < 16; a++) begin
            ram_address = 4'(a);
            tick();
            chk("sweep_read", ram_output, exp_word[a]);
        end

        // Reset while the FSM sits in WRITE
        wd0 = wd_count;
        CE_bar = 1'b1; prog_mode = 1'b1; prog_address = 4'h9; prog_data = 8'h77;
        prog_write = 1'b1;
        repeat (D) tick();
        chk("midwrite_busy", {7'd0, busy}, 8'h01);
        CLR = 1'b1;
        tick();
        CLR = 1'b0; prog_write = 1'b0;
        repeat (16) tick();
        chk("midwrite_idle", {7'd0, busy}, 8'h00);
        chk("midwrite_no_pulse", 8'(wd_count - wd0), 8'd0);
        for (int a = 0; a < 16; a++) begin
            prog_address = 4'(a);
            tick();
            chk("midwrite_zero", prog_readback, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
